mgr_cntl_noc_tx: RTL



---
 rtl/mgr_cntl_noc_tx_if.sv | 51 +++++
 rtl/mgr_cntl_noc_tx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mgr_cntl_noc_tx_if.sv
// Handshake bundle for the manager-controller transmit packetizer.
//  - request channel : req_valid/req_ready plus type, ptype, mgrId and length
//  - payload channel : pl_valid/pl_ready plus payload word
//  - NoC channel     : mcntl__noc__* beat fields out, noc__mcntl__ready back
// The master modport is the packet source / NoC sink side; the slave modport
// is the packetizer itself.
interface mgr_cntl_noc_tx_if #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TYPE_W   = 3,
  parameter int unsigned PTYPE_W  = 4,
  parameter int unsigned MGR_ID_W = 6,
  parameter int unsigned LEN_W    = 5
);
  logic                req_valid;
  logic                req_ready;
  logic [TYPE_W-1:0]   req_type;
  logic [PTYPE_W-1:0]  req_ptype;
  logic [MGR_ID_W-1:0] req_mgrId;
  logic [LEN_W-1:0]    req_len;

  logic                pl_valid;
  logic                pl_ready;
  logic [DATA_W-1:0]   pl_data;

  logic                mcntl__noc__valid;
  logic [1:0]          mcntl__noc__cntl;
  logic [TYPE_W-1:0]   mcntl__noc__type;
  logic [PTYPE_W-1:0]  mcntl__noc__ptype;
  logic [DATA_W-1:0]   mcntl__noc__data;
  logic                mcntl__noc__pvalid;
  logic [MGR_ID_W-1:0] mcntl__noc__mgrId;
  logic                noc__mcntl__ready;

  modport master (
    output req_valid, req_type, req_ptype, req_mgrId, req_len,
    output pl_valid, pl_data,
    output noc__mcntl__ready,
    input  req_ready, pl_ready,
    input  mcntl__noc__valid, mcntl__noc__cntl, mcntl__noc__type, mcntl__noc__ptype,
    input  mcntl__noc__data, mcntl__noc__pvalid, mcntl__noc__mgrId
  );

  modport slave (
    input  req_valid, req_type, req_ptype, req_mgrId, req_len,
    input  pl_valid, pl_data,
    input  noc__mcntl__ready,
    output req_ready, pl_ready,
    output mcntl__noc__valid, mcntl__noc__cntl, mcntl__noc__type, mcntl__noc__ptype,
    output mcntl__noc__data, mcntl__noc__pvalid, mcntl__noc__mgrId
  );
endinterface

// File: rtl/mgr_cntl_noc_tx.sv
// Manager-controller transmit packetizer (mcntl -> NoC).
// Buffers payload words in a FIFO and, once a request's whole payload is
// present, emits the packet as an unbroken registered beat stream.
// Ports:
//  clk              clock
//  reset_poweron_n  asynchronous active-low reset
//  bus              request / payload / NoC channels (slave side)
//  tx_busy          FSM not idle, or output register holds a beat
//  tx_err           one-cycle pulse after a request with bad length
//  pkt_count        packets transferred, wraps modulo 2**16
module mgr_cntl_noc_tx #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned TYPE_W     = 3,
  parameter int unsigned PTYPE_W    = 4,
  parameter int unsigned MGR_ID_W   = 6,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset_poweron_n,
  mgr_cntl_noc_tx_if.slave     bus,
  output logic                 tx_busy,
  output logic                 tx_err,
  output logic [15:0]          pkt_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam logic [1:0] C_SOM_EOM = 2'b11;
  localparam logic [1:0] C_SOM     = 2'b01;
  localparam logic [1:0] C_MOM     = 2'b00;
  localparam logic [1:0] C_EOM     = 2'b10;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         fcount;
  logic                push, pop;

  logic [1:0]          state;
  logic [TYPE_W-1:0]   lat_type;
  logic [PTYPE_W-1:0]  lat_ptype;
  logic [MGR_ID_W-1:0] lat_mgrId;
  logic [LEN_W-1:0]    remaining;

  logic out_load, req_acc, len_ok, fifo_enough, last_word, beat_go;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.pl_ready  = (fcount != (AW+1)'(FIFO_DEPTH));

  assign push        = bus.pl_valid && bus.pl_ready;
  assign out_load    = !bus.mcntl__noc__valid || bus.noc__mcntl__ready;
  assign req_acc     = bus.req_valid && bus.req_ready;
  assign len_ok      = (bus.req_len != '0) && (32'(bus.req_len) <= FIFO_DEPTH);
  assign fifo_enough = (32'(fcount) >= 32'(remaining));
  assign last_word   = (remaining == LEN_W'(1));
  // Once in SEND the whole payload is already buffered, so only the
  // output register can hold a beat back.
  assign beat_go     = out_load && (((state == S_WAIT) && fifo_enough) || (state == S_SEND));
  assign pop         = beat_go;

  assign tx_busy = (state != S_IDLE) || bus.mcntl__noc__valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pl_data;
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fcount <= fcount + (AW+1)'(1);
        2'b01:   fcount <= fcount - (AW+1)'(1);
        default: fcount <= fcount;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state     <= S_IDLE;
      lat_type  <= '0;
      lat_ptype <= '0;
      lat_mgrId <= '0;
      remaining <= '0;
      tx_err    <= 1'b0;
    end else begin
      tx_err <= req_acc && !len_ok;
      case (state)
        S_IDLE: begin
          if (req_acc && len_ok) begin
            lat_type  <= bus.req_type;
            lat_ptype <= bus.req_ptype;
            lat_mgrId <= bus.req_mgrId;
            remaining <= bus.req_len;
            state     <= S_WAIT;
          end
        end
        S_WAIT, S_SEND: begin
          if (beat_go) begin
            remaining <= remaining - LEN_W'(1);
            if (last_word)            state <= S_IDLE;
            else if (state == S_WAIT) state <= S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      bus.mcntl__noc__valid  <= 1'b0;
      bus.mcntl__noc__cntl   <= '0;
      bus.mcntl__noc__type   <= '0;
      bus.mcntl__noc__ptype  <= '0;
      bus.mcntl__noc__data   <= '0;
      bus.mcntl__noc__pvalid <= 1'b0;
      bus.mcntl__noc__mgrId  <= '0;
    end else if (out_load) begin
      if (beat_go) begin
        bus.mcntl__noc__valid  <= 1'b1;
        bus.mcntl__noc__pvalid <= 1'b1;
        bus.mcntl__noc__data   <= mem[rd_ptr];
        bus.mcntl__noc__type   <= lat_type;
        bus.mcntl__noc__ptype  <= lat_ptype;
        bus.mcntl__noc__mgrId  <= lat_mgrId;
        if (state == S_WAIT) bus.mcntl__noc__cntl <= last_word ? C_SOM_EOM : C_SOM;
        else                 bus.mcntl__noc__cntl <= last_word ? C_EOM : C_MOM;
      end else begin
        bus.mcntl__noc__valid  <= 1'b0;
        bus.mcntl__noc__pvalid <= 1'b0;
      end
    end
  end

  // cntl[1] is set only for EOM and SOM_EOM, i.e. the closing beat.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      pkt_count <= '0;
    end else if (bus.mcntl__noc__valid && bus.noc__mcntl__ready && bus.mcntl__noc__cntl[1]) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule
